exec_sequencer: RTL and testbench

Execute-stage sequencer that sits directly upstream of the 8×8 register file. It accepts one 16-bit instruction per handshake, reads two source registers through the file's combinational read ports, and computes an 8-bit ALU result. It writes the result back through the file's single write port and maintains zero/carry flags. It is a fixed-latency four-state FSM, one instruction in flight at a time.

---
 rtl/exec_sequencer_pkg.sv | 39 +++
 rtl/exec_sequencer_if.sv | 34 +++
 rtl/exec_sequencer_alu8.sv | 49 ++++
 rtl/exec_sequencer.sv | 111 +++++++++++
 tb/tb_exec_sequencer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the execute-stage sequencer: opcodes, FSM states,
// instruction field positions and opcode classification helpers.
package exec_seq_pkg;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int DST_HI = 11;
  localparam int DST_LO = 9;
  localparam int S1_HI  = 8;
  localparam int S1_LO  = 6;
  localparam int S2_HI  = 5;
  localparam int S2_LO  = 3;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  // Opcodes 0xC..0xF are illegal and have no enum member; they fall
  // through to NOP behaviour wherever the op is decoded.
  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
    OP_OR  = 4'h4, OP_XOR = 4'h5, OP_NOT = 4'h6, OP_SHL = 4'h7,
    OP_SHR = 4'h8, OP_MOV = 4'h9, OP_LDI = 4'hA, OP_CMP = 4'hB
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  function automatic logic is_write_op(input logic [3:0] op);
    return (op >= 4'h1) && (op <= 4'hA);
  endfunction

  function automatic logic is_illegal_op(input logic [3:0] op);
    return op >= 4'hC;
  endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Instruction handshake plus register-file port bundle.
// slave  : the sequencer side.
// master : upstream instruction source together with the register file.
interface exec_sequencer_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          instr_valid;
  logic [15:0]   instr;
  logic          instr_ready;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic [DW-1:0] rd_data1;
  logic [DW-1:0] rd_data2;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          flag_z;
  logic          flag_c;
  logic          done;
  logic          illegal_op;

  modport slave (
    input  instr_valid, instr, rd_data1, rd_data2,
    output instr_ready, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
           flag_z, flag_c, done, illegal_op
  );

  modport master (
    output instr_valid, instr, rd_data1, rd_data2,
    input  instr_ready, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
           flag_z, flag_c, done, illegal_op
  );
endinterface

// File: rtl/exec_sequencer_alu8.sv
// Combinational ALU. Ops that must not disturb flags (NOP/MOV/LDI/illegal)
// pass the incoming flags straight through.
module alu8
  import exec_seq_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    i_op,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [DW-1:0] i_imm8,
  input  logic          i_c_in,
  input  logic          i_z_in,
  output logic [DW-1:0] o_result,
  output logic          o_z_out,
  output logic          o_c_out
);

  logic [DW:0] w_sum;
  logic [DW:0] w_diff;
  logic        w_upd_z;

  // Extra top bit of the difference is the unsigned borrow (a < b).
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  // Result and flag selection by opcode.
  always_comb begin
    o_result = '0;
    o_c_out  = i_c_in;
    w_upd_z  = 1'b0;
    case (i_op)
      OP_ADD: begin o_result = w_sum[DW-1:0];  o_c_out = w_sum[DW];  w_upd_z = 1'b1; end
      OP_SUB,
      OP_CMP: begin o_result = w_diff[DW-1:0]; o_c_out = w_diff[DW]; w_upd_z = 1'b1; end
      OP_AND: begin o_result = i_a & i_b;      o_c_out = 1'b0;       w_upd_z = 1'b1; end
      OP_OR:  begin o_result = i_a | i_b;      o_c_out = 1'b0;       w_upd_z = 1'b1; end
      OP_XOR: begin o_result = i_a ^ i_b;      o_c_out = 1'b0;       w_upd_z = 1'b1; end
      OP_NOT: begin o_result = ~i_a;           o_c_out = 1'b0;       w_upd_z = 1'b1; end
      OP_SHL: begin o_result = {i_a[DW-2:0], 1'b0}; o_c_out = i_a[DW-1]; w_upd_z = 1'b1; end
      OP_SHR: begin o_result = {1'b0, i_a[DW-1:1]}; o_c_out = i_a[0];    w_upd_z = 1'b1; end
      OP_MOV: o_result = i_a;
      OP_LDI: o_result = i_imm8;
      default: o_result = '0;
    endcase
    o_z_out = w_upd_z ? (o_result == '0) : i_z_in;
  end

endmodule

// File: rtl/exec_sequencer.sv
// Four-state execute sequencer: IDLE -> READ -> EXEC -> WRITE, one
// instruction in flight, result written back in WRITE.
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic             clk,
  input  logic             reset,
  exec_sequencer_if.slave  bus
);

  state_e        r_state, w_next;
  logic [15:0]   r_instr;
  logic [DW-1:0] r_a, r_b, r_result;
  logic          r_wen, r_z, r_c;

  logic [3:0]    w_op;
  logic [AW-1:0] w_dst, w_src1, w_src2;
  logic [DW-1:0] w_imm, w_res;
  logic          w_z, w_c, w_accept;

  assign w_op   = r_instr[OP_HI:OP_LO];
  assign w_dst  = r_instr[DST_HI:DST_LO];
  assign w_src1 = r_instr[S1_HI:S1_LO];
  assign w_src2 = r_instr[S2_HI:S2_LO];
  assign w_imm  = r_instr[IMM_HI:IMM_LO];

  assign w_accept = bus.instr_valid && (r_state == S_IDLE);

  alu8 #(.DW(DW)) u_alu (
    .i_op     (w_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .i_imm8   (w_imm),
    .i_c_in   (r_c),
    .i_z_in   (r_z),
    .o_result (w_res),
    .o_z_out  (w_z),
    .o_c_out  (w_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: fixed walk through the stages once an instruction lands.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_READ;
      S_READ:  w_next = S_EXEC;
      S_EXEC:  w_next = S_WRITE;
      S_WRITE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Instruction latch, operand capture and result/flag registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_instr  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_wen    <= 1'b0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
    end else begin
      if (w_accept) r_instr <= bus.instr;
      if (r_state == S_READ) begin
        r_a <= bus.rd_data1;
        r_b <= bus.rd_data2;
      end
      if (r_state == S_EXEC) begin
        r_result <= w_res;
        r_wen    <= is_write_op(w_op);
        r_z      <= w_z;
        r_c      <= w_c;
      end
    end
  end

  // Outputs. Strobes are gated by reset so a reset landing in WRITE
  // cannot commit a register-file write at that same edge.
  always_comb begin
    bus.instr_ready = reset && (r_state == S_IDLE);
    bus.rd_addr1    = (r_state != S_IDLE) ? w_src1 : '0;
    bus.rd_addr2    = (r_state != S_IDLE) ? w_src2 : '0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    // Operands are registered, so the live ALU result in EXEC equals the
    // value registered for WRITE; wr_data is stable across both cycles.
    if (r_state == S_EXEC) begin
      bus.wr_addr = w_dst;
      bus.wr_data = w_res;
    end else if (r_state == S_WRITE) begin
      bus.wr_addr = w_dst;
      bus.wr_data = r_result;
    end
    bus.done       = reset && (r_state == S_WRITE);
    bus.wr_en      = bus.done && r_wen;
    bus.illegal_op = bus.done && is_illegal_op(w_op);
    bus.flag_z     = r_z;
    bus.flag_c     = r_c;
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed retirement expectations,
// a negedge monitor pops and compares whenever done pulses.
module tb_exec_sequencer;
  import exec_seq_pkg::*;

  typedef struct {
    logic       wen;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic       z;
    logic       c;
    logic       ill;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t q[$];
  int   n_chk = 0, n_fail = 0, n_wr = 0, n_exp_wr = 0;
  logic [7:0] rf [8];

  exec_sequencer_if #(.DW(8), .AW(3)) bus ();

  exec_sequencer #(.DW(8), .AW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Register file model: combinational reads, write on rising edge.
  assign bus.rd_data1 = rf[bus.rd_addr1];
  assign bus.rd_data2 = rf[bus.rd_addr2];
  always @(posedge clk) if (bus.wr_en === 1'b1) rf[bus.wr_addr] <= bus.wr_data;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compare each retirement against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (bus.wr_en === 1'b1) begin
      n_wr++;
      chk("wr_en_outside_write", 16'(bus.done), 16'h1);
    end
    if (bus.done === 1'b1) begin
      if (q.size() == 0) chk("unexpected_done", 16'h1, 16'h0);
      else begin
        e = q.pop_front();
        chk("wr_en", 16'(bus.wr_en), 16'(e.wen));
        if (e.wen) begin
          chk("wr_addr", 16'(bus.wr_addr), 16'(e.waddr));
          chk("wr_data", 16'(bus.wr_data), 16'(e.wdata));
        end
        chk("flag_z", 16'(bus.flag_z), 16'(e.z));
        chk("flag_c", 16'(bus.flag_c), 16'(e.c));
        chk("illegal_op", 16'(bus.illegal_op), 16'(e.ill));
      end
    end
  end

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] d,
                                      input logic [2:0] s1, input logic [2:0] s2);
    return {op, d, s1, s2, 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] d, input logic [7:0] imm);
    return {4'hA, d, 1'b0, imm};
  endfunction

  function automatic exp_t mk(input logic wen, input logic [2:0] a, input logic [7:0] dt,
                              input logic z, input logic c, input logic ill);
    exp_t e;
    e.wen = wen; e.waddr = a; e.wdata = dt; e.z = z; e.c = c; e.ill = ill;
    return e;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (bus.instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 16'(bus.instr_ready), 16'h1);
  endtask

  // Issue one instruction; checks the 3-cycle busy window and re-ready.
  // With hold, valid stays high and instr churns while busy.
  task automatic issue(input logic [15:0] ins, input exp_t e, input bit hold);
    q.push_back(e);
    if (e.wen) n_exp_wr++;
    wait_ready();
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.instr_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("busy_ready", 16'(bus.instr_ready), 16'h0);
      if (hold) begin
        chk("rd_addr1_hold", 16'(bus.rd_addr1), 16'(ins[8:6]));
        chk("rd_addr2_hold", 16'(bus.rd_addr2), 16'(ins[5:3]));
        if (k >= 2) chk("wr_addr_hold", 16'(bus.wr_addr), 16'(ins[11:9]));
        bus.instr = 16'($urandom);
        if (k == 3) bus.instr_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("ready_after_4", 16'(bus.instr_ready), 16'h1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    reset = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 16'(bus.instr_ready), 16'h0);
    chk("reset_done", 16'(bus.done), 16'h0);
    chk("reset_wr_en", 16'(bus.wr_en), 16'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", 16'(bus.instr_ready), 16'h1);
    chk("post_reset_z", 16'(bus.flag_z), 16'h0);
    chk("post_reset_c", 16'(bus.flag_c), 16'h0);
    chk("post_reset_rd_addr1", 16'(bus.rd_addr1), 16'h0);
    chk("post_reset_wr_data", 16'(bus.wr_data), 16'h0);

    issue(ldi(3'd1, 8'h7F),           mk(1, 3'd1, 8'h7F, 0, 0, 0), 0);
    issue(ldi(3'd2, 8'h81),           mk(1, 3'd2, 8'h81, 0, 0, 0), 0);
    issue(enc(OP_ADD, 3'd3, 3'd1, 3'd2), mk(1, 3'd3, 8'h00, 1, 1, 0), 0);
    issue(16'hE000,                   mk(0, 3'd0, 8'h00, 1, 1, 1), 0);
    issue(enc(OP_SUB, 3'd4, 3'd2, 3'd1), mk(1, 3'd4, 8'h02, 0, 0, 0), 0);
    issue(enc(OP_CMP, 3'd0, 3'd1, 3'd2), mk(0, 3'd0, 8'h00, 0, 1, 0), 0);
    issue(ldi(3'd5, 8'h01),           mk(1, 3'd5, 8'h01, 0, 1, 0), 0);
    issue(enc(OP_SHL, 3'd5, 3'd5, 3'd0), mk(1, 3'd5, 8'h02, 0, 0, 0), 0);
    issue(enc(OP_SHL, 3'd5, 3'd5, 3'd0), mk(1, 3'd5, 8'h04, 0, 0, 0), 0);
    issue(enc(OP_NOT, 3'd7, 3'd2, 3'd0), mk(1, 3'd7, 8'h7E, 0, 0, 0), 0);
    issue(enc(OP_XOR, 3'd7, 3'd1, 3'd2), mk(1, 3'd7, 8'hFE, 0, 0, 0), 1);
    issue(enc(OP_AND, 3'd7, 3'd3, 3'd1), mk(1, 3'd7, 8'h00, 1, 0, 0), 0);
    issue(enc(OP_SHR, 3'd7, 3'd1, 3'd0), mk(1, 3'd7, 8'h3F, 0, 1, 0), 0);
    issue(ldi(3'd6, 8'h55),           mk(1, 3'd6, 8'h55, 0, 1, 0), 0);

    chk("rf_r3", 16'(rf[3]), 16'h00);
    chk("rf_r4", 16'(rf[4]), 16'h02);
    chk("rf_r5", 16'(rf[5]), 16'h04);
    chk("rf_r7", 16'(rf[7]), 16'h3F);

    // Abort ADD r6 with reset during EXEC.
    wait_ready();
    bus.instr = enc(OP_ADD, 3'd6, 3'd1, 3'd2);
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_exec_ready", 16'(bus.instr_ready), 16'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_exec_ready_after", 16'(bus.instr_ready), 16'h1);
    chk("abort_exec_z", 16'(bus.flag_z), 16'h0);
    chk("abort_exec_c", 16'(bus.flag_c), 16'h0);
    repeat (4) @(negedge clk);
    chk("abort_exec_r6", 16'(rf[6]), 16'h55);

    // Abort LDI r6 with reset landing while in WRITE.
    wait_ready();
    bus.instr = ldi(3'd6, 8'hAA);
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_write_wr_en", 16'(bus.wr_en), 16'h0);
    chk("abort_write_done", 16'(bus.done), 16'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_write_r6", 16'(rf[6]), 16'h55);
    chk("abort_write_ready", 16'(bus.instr_ready), 16'h1);

    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drain", 16'(q.size()), 16'h0);
    chk("write_count", 16'(n_wr), 16'(n_exp_wr));

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
